// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding and the BCD digit width.
package bin2bcd_seq_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: adds 3 to a BCD digit of 5..9 so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
    import bin2bcd_seq_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] adj
);

    // Legal digits stay <= 9, so 9+3=12 still fits in four bits.
    assign adj = (digit >= DIGIT_W'(5)) ? digit + DIGIT_W'(3) : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock.
// Handshake: start is accepted whenever busy=0 (IDLE or DONE); done pulses once per accepted start.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [BIN_W-1:0]           bin,
    output logic                       busy,
    output logic                       done,
    output logic [DIGIT_W*DIGITS-1:0]  bcd,
    output logic                       overflow
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CAT_W = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    // state is kept as a plain named signal so checkers can bind to it.
    state_t             state;
    state_t             state_next;
    logic [BIN_W-1:0]   bin_reg;
    logic [BCD_W-1:0]   scratch;
    logic [BCD_W-1:0]   scratch_adj;
    logic               sticky;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               last_shift;
    logic               carry;
    logic [CAT_W-1:0]   shifted;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_digit_adj u_adj (
                .digit (scratch[gi*DIGIT_W +: DIGIT_W]),
                .adj   (scratch_adj[gi*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

    // The bit falling off the top digit is the overflow contribution.
    assign {carry, shifted} = {scratch_adj, bin_reg, 1'b0};
    assign last_shift       = (state == ST_SHIFT) && (cnt == CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_SHIFT;
            ST_SHIFT: if (cnt == CNT_W'(1)) state_next = ST_DONE;
            ST_DONE:  state_next = start ? ST_SHIFT : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        accept = 1'b0;
        case (state)
            ST_IDLE:  accept = start;
            ST_SHIFT: busy   = 1'b1;
            ST_DONE: begin
                done   = 1'b1;
                accept = start;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_reg  <= '0;
            scratch  <= '0;
            sticky   <= 1'b0;
            cnt      <= '0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            bin_reg <= bin;
            scratch <= '0;
            sticky  <= 1'b0;
            cnt     <= CNT_W'(BIN_W);
        end else if (state == ST_SHIFT) begin
            {scratch, bin_reg} <= shifted;
            sticky             <= sticky | carry;
            cnt                <= cnt - CNT_W'(1);
            // Results publish only on the final shift, never partially.
            if (last_shift) begin
                bcd      <= shifted[CAT_W-1 -: BCD_W];
                overflow <= sticky | carry;
            end
        end
    end

    a_done_single: assert property (@(posedge clk) disable iff (rst) done |=> !done);
    a_busy_done_excl: assert property (@(posedge clk) disable iff (rst) !(busy && done));
    a_state_legal: assert property (@(posedge clk) disable iff (rst) state != 2'd3);

    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_chk
            a_digit_legal: assert property (@(posedge clk) disable iff (rst)
                done |-> (bcd[gi*DIGIT_W +: DIGIT_W] <= DIGIT_W'(9)));
        end
    endgenerate

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: an 8-bit/3-digit instance and a
// 10-bit/3-digit instance checked against an arithmetic decimal model.
module tb_bin2bcd_seq;

    localparam int BIN_W_A = 8;
    localparam int BIN_W_B = 10;
    localparam int DIGITS  = 3;

    logic        clk = 1'b0;
    logic        rst;

    logic        start_a;
    logic [7:0]  bin_a;
    logic        busy_a, done_a, ovf_a;
    logic [11:0] bcd_a;

    logic        start_b;
    logic [9:0]  bin_b;
    logic        busy_b, done_b, ovf_b;
    logic [11:0] bcd_b;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;
    logic prev_done_a = 1'b0;
    logic prev_done_b = 1'b0;

    logic [12:0] exp_q[$];
    logic [12:0] exp_b_q[$];
    int          done_cyc_q[$];

    bin2bcd_seq #(.BIN_W(BIN_W_A), .DIGITS(DIGITS)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .bin(bin_a),
        .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(ovf_a)
    );

    bin2bcd_seq #(.BIN_W(BIN_W_B), .DIGITS(DIGITS)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .bin(bin_b),
        .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(ovf_b)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model and checking ----------------
    // Expected {overflow, bcd}: decimal digits of v mod 1000, flag if v > 999.
    function automatic logic [12:0] model(input int v);
        int m;
        m = v % 1000;
        model = {(v > 999) ? 1'b1 : 1'b0, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (done_a) begin
                if (exp_q.size() == 0) fail_now("spurious_done_a");
                else check("result_a", {19'd0, ovf_a, bcd_a}, {19'd0, exp_q.pop_front()});
                check("done_width_a", {31'd0, prev_done_a}, 32'd0);
                for (int i = 0; i < DIGITS; i++)
                    check("digit_legal_a", {31'd0, bcd_a[4*i +: 4] <= 4'd9}, 32'd1);
                done_cyc_q.push_back(cyc);
                done_cnt_a++;
            end
            if (done_b) begin
                if (exp_b_q.size() == 0) fail_now("spurious_done_b");
                else check("result_b", {19'd0, ovf_b, bcd_b}, {19'd0, exp_b_q.pop_front()});
                check("done_width_b", {31'd0, prev_done_b}, 32'd0);
                done_cnt_b++;
            end
        end
        prev_done_a = done_a;
        prev_done_b = done_b;
    end

    // ---------------- driver tasks ----------------
    task automatic start_conv_a(input int v);
        @(negedge clk);
        start_a = 1'b1;
        bin_a   = 8'(v);
        @(posedge clk);
        #1;
        exp_q.push_back(model(v));
        acc_cyc = cyc;
        start_a = 1'b0;
        bin_a   = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_done_a(input string name);
        int n;
        int busy_n;
        int exp_busy;
        n = 0;
        busy_n = 0;
        exp_busy = BIN_W_A - (cyc - acc_cyc);
        while (!done_a && n < 40) begin
            if (busy_a) busy_n++;
            @(posedge clk);
            #1;
            n++;
        end
        if (!done_a) fail_now({name, "_timeout"});
        else begin
            check({name, "_latency"}, cyc - acc_cyc, BIN_W_A);
            check({name, "_busy_cycles"}, busy_n, exp_busy);
        end
    endtask

    task automatic run_b(input int v);
        int n;
        @(negedge clk);
        start_b = 1'b1;
        bin_b   = 10'(v);
        @(posedge clk);
        #1;
        exp_b_q.push_back(model(v));
        start_b = 1'b0;
        bin_b   = 10'($urandom_range(0, 1023));
        n = 0;
        while (!done_b && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!done_b) fail_now("b_timeout");
        else check("b_latency", n, BIN_W_B);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int dc;
        rst = 1'b1;
        start_a = 1'b0; bin_a = '0;
        start_b = 1'b0; bin_b = '0;
        #12;
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_done", {31'd0, done_a}, 32'd0);
        check("rst_bcd", {20'd0, bcd_a}, 32'd0);
        check("rst_ovf", {31'd0, ovf_a}, 32'd0);
        check("rst_bcd_b", {20'd0, bcd_b}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        check("model_255", {19'd0, model(255)}, 32'h0255);
        check("model_1023", {19'd0, model(1023)}, 32'h1023);
        check("model_1000", {19'd0, model(1000)}, 32'h1000);

        // 255: full-width conversion, then results hold after done.
        start_conv_a(255);
        wait_done_a("c255");
        check("lit_255", {20'd0, bcd_a}, 32'h255);
        check("lit_255_ovf", {31'd0, ovf_a}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("hold_255", {20'd0, bcd_a}, 32'h255);
        check("hold_done_low", {31'd0, done_a}, 32'd0);

        // 0, 99, 100 back-to-back with start held through DONE.
        done_cyc_q.delete();
        @(negedge clk);
        start_a = 1'b1;
        bin_a   = 8'd0;
        @(posedge clk);
        #1;
        exp_q.push_back(model(0));
        bin_a = 8'd99;
        repeat (BIN_W_A + 1) @(posedge clk);
        #1;
        exp_q.push_back(model(99));
        bin_a = 8'd100;
        repeat (BIN_W_A + 1) @(posedge clk);
        #1;
        exp_q.push_back(model(100));
        start_a = 1'b0;
        bin_a   = 8'd0;
        repeat (BIN_W_A + 4) @(posedge clk);
        #1;
        check("b2b_count", done_cyc_q.size(), 3);
        if (done_cyc_q.size() == 3) begin
            check("b2b_gap1", done_cyc_q[1] - done_cyc_q[0], BIN_W_A + 1);
            check("b2b_gap2", done_cyc_q[2] - done_cyc_q[1], BIN_W_A + 1);
        end
        check("lit_100", {20'd0, bcd_a}, 32'h100);

        // 59 with start re-asserted mid-conversion: must be ignored.
        dc = done_cnt_a;
        start_conv_a(59);
        repeat (2) @(negedge clk);
        start_a = 1'b1;
        bin_a   = 8'd7;
        repeat (3) @(negedge clk);
        start_a = 1'b0;
        wait_done_a("c59");
        repeat (5) @(posedge clk);
        #1;
        check("ign_pulses", done_cnt_a - dc, 1);
        check("lit_059", {20'd0, bcd_a}, 32'h059);

        // Asynchronous reset mid-shift discards the conversion.
        start_conv_a(200);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy_a}, 32'd0);
        check("arst_done", {31'd0, done_a}, 32'd0);
        check("arst_bcd", {20'd0, bcd_a}, 32'd0);
        check("arst_ovf", {31'd0, ovf_a}, 32'd0);
        exp_q.delete();
        dc = done_cnt_a;
        @(negedge clk);
        rst = 1'b0;
        repeat (BIN_W_A + 3) @(posedge clk);
        #1;
        check("arst_no_done", done_cnt_a - dc, 0);
        start_conv_a(200);
        wait_done_a("c200");
        check("lit_200", {20'd0, bcd_a}, 32'h200);

        // 10-bit instance: overflow, then sticky flag cleared by a new start.
        run_b(1023);
        check("lit_1023", {19'd0, ovf_b, bcd_b}, 32'h1023);
        run_b(999);
        check("lit_999", {19'd0, ovf_b, bcd_b}, 32'h0999);
        run_b(1000);
        check("lit_1000", {19'd0, ovf_b, bcd_b}, 32'h1000);
        run_b(512);

        // Every 8-bit input against the model.
        for (int v = 0; v < 256; v++) begin
            start_conv_a(v);
            wait_done_a("sweep");
        end

        repeat (3) @(posedge clk);
        #1;
        check("exp_q_drained", exp_q.size(), 0);
        check("exp_b_q_drained", exp_b_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
